// File: rtl/ps2_pkg.sv
// Shared PS/2 receive types and constants.
// Used by the framer and its bench.
package ps2_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } ps2_state_e;

  localparam int FRAME_BITS      = 11;
  localparam int TIMEOUT_DEFAULT = 100000;

endpackage

// File: rtl/ps2_rx_framer.sv
// PS/2 device-to-host frame receiver.
// Decodes 11-bit frames into bytes with parity, stop and timeout checks.
module ps2_rx_framer
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       ps2_clk_f,
  input  logic       ps2_data_f,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_overflow
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  ps2_state_e r_state;
  ps2_state_e w_state_nx;

  logic          r_clk_q;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_perr;
  logic          r_ferr;
  logic          r_ovf;

  logic w_fall;
  logic w_timeout;
  logic w_stop_evt;
  logic w_par_ok;
  logic w_good;
  logic w_ack_acc;

  assign w_fall     = r_clk_q & ~ps2_clk_f;
  assign w_timeout  = (r_state != S_IDLE) & ~w_fall &
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_stop_evt = (r_state == S_STOP) & w_fall;
  assign w_par_ok   = ^{r_shift, r_par};
  assign w_good     = w_stop_evt & ps2_data_f & w_par_ok;
  assign w_ack_acc  = rx_ack & r_valid;

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_fall && !ps2_data_f) w_state_nx = S_DATA;
      S_DATA:
        if (w_fall && r_idx == 3'd7) w_state_nx = S_PARITY;
      S_PARITY:
        if (w_fall) w_state_nx = S_STOP;
      S_STOP:
        if (w_fall) w_state_nx = S_IDLE;
      default:
        w_state_nx = S_IDLE;
    endcase
    if (w_timeout) w_state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_clk_q <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_clk_q <= ps2_clk_f;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_IDLE || w_fall || w_timeout)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
      if (r_state == S_IDLE || w_timeout)
        r_idx <= '0;
      else if (r_state == S_DATA && w_fall) begin
        r_shift[r_idx] <= ps2_data_f;
        r_idx          <= r_idx + 1'b1;
      end
      if (r_state == S_PARITY && w_fall)
        r_par <= ps2_data_f;
    end
  end

  // An ack in the same cycle frees the holding slot for a new byte.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_perr <= w_stop_evt & ps2_data_f & ~w_par_ok;
      r_ferr <= (w_stop_evt & ~ps2_data_f) | w_timeout;
      if (w_good && (!r_valid || rx_ack)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_ack_acc) begin
        r_valid <= 1'b0;
      end
      if (w_good && r_valid && !rx_ack)
        r_ovf <= 1'b1;
      else if (w_ack_acc)
        r_ovf <= 1'b0;
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign parity_err  = r_perr;
  assign frame_err   = r_ferr;
  assign rx_overflow = r_ovf;

endmodule

// File: tb/tb_ps2_rx_framer.sv
// Bench for ps2_rx_framer: directed table, corner sequences
// and random frames against a byte-level reference model.
module tb_ps2_rx_framer;
  import ps2_pkg::*;

  localparam int TO = 200;

  logic       clk;
  logic       rstn;
  logic       ps2_clk_f;
  logic       ps2_data_f;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       parity_err;
  logic       frame_err;
  logic       rx_overflow;

  ps2_rx_framer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ps2_clk_f  (ps2_clk_f),
    .ps2_data_f (ps2_data_f),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_overflow(rx_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int n_perr = 0;
  int n_ferr = 0;
  int x_perr = 0;
  int x_ferr = 0;

  always @(negedge clk) begin
    if (rstn) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
    end
  end

  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ovf;
  logic       m_pe;
  logic       m_fe;

  typedef struct {
    bit         is_ack;
    logic [7:0] d;
    bit         pok;
    bit         stp;
    bit         ack;
    logic       ev;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_bits(input logic [7:0] d,
                                          input bit pok,
                                          input bit stp);
    logic p;
    p = pok ? ~(^d) : (^d);
    return {stp, p, d, 1'b0};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ovf   = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit pok,
                             input bit stp, input bit ack);
    bit good;
    good = stp && pok;
    m_pe = stp && !pok;
    m_fe = !stp;
    if (m_pe) x_perr++;
    if (m_fe) x_ferr++;
    if (good && m_valid && !ack) m_ovf = 1'b1;
    else if (ack && m_valid) m_ovf = 1'b0;
    if (good && (!m_valid || ack)) begin
      m_data  = d;
      m_valid = 1'b1;
    end else if (ack && m_valid) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] b, input int n,
                           input bit ack_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ps2_data_f = b[i];
      ps2_clk_f  = 1'b0;
      if (i == n - 1 && ack_last) rx_ack = 1'b1;
      @(posedge clk); #1;
      rx_ack = 1'b0;
      if (i != n - 1) begin
        repeat (2) @(posedge clk);
        #1 ps2_clk_f = 1'b1;
        repeat (3) @(posedge clk);
      end
    end
  endtask

  task automatic rise();
    @(posedge clk); #1;
    ps2_clk_f = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] d, input bit pok,
                          input bit stp, input bit ack);
    send_bits(mk_bits(d, pok, stp), FRAME_BITS, ack);
    model_frame(d, pok, stp, ack);
    @(negedge clk);
  endtask

  task automatic end_frame(input string nm);
    rise();
    @(negedge clk);
    chk({nm, "_perr_pulse_end"}, parity_err, 0);
    chk({nm, "_ferr_pulse_end"}, frame_err, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic do_ack();
    @(posedge clk); #1 rx_ack = 1'b1;
    @(posedge clk); #1 rx_ack = 1'b0;
    model_ack();
    @(negedge clk);
  endtask

  task automatic chk_model(input string nm);
    chk({nm, "_valid"}, rx_valid, m_valid);
    chk({nm, "_data"}, rx_data, m_data);
    chk({nm, "_ovf"}, rx_overflow, m_ovf);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    string nm;
    rstn       = 1'b0;
    ps2_clk_f  = 1'b1;
    ps2_data_f = 1'b1;
    rx_ack     = 1'b0;
    model_reset();
    m_pe = 1'b0;
    m_fe = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovf", rx_overflow, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    //             ack  d      pok stp ack  v  d      p  f  o
    tbl.push_back('{0, 8'h1C, 1, 1, 0, 1, 8'h1C, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h1C, 0, 0, 0});
    tbl.push_back('{0, 8'hF0, 0, 1, 0, 0, 8'h1C, 1, 0, 0});
    tbl.push_back('{0, 8'h5A, 1, 0, 0, 0, 8'h1C, 0, 1, 0});
    tbl.push_back('{0, 8'h29, 1, 1, 0, 1, 8'h29, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h29, 0, 0, 0});
    tbl.push_back('{0, 8'h11, 1, 1, 0, 1, 8'h11, 0, 0, 0});
    tbl.push_back('{0, 8'h22, 1, 1, 0, 1, 8'h11, 0, 0, 1});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h11, 0, 0, 0});
    tbl.push_back('{0, 8'h11, 1, 1, 0, 1, 8'h11, 0, 0, 0});
    tbl.push_back('{0, 8'h33, 1, 1, 1, 1, 8'h33, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h33, 0, 0, 0});
    tbl.push_back('{0, 8'h44, 0, 0, 0, 0, 8'h33, 0, 1, 0});
    tbl.push_back('{0, 8'h55, 1, 1, 0, 1, 8'h55, 0, 0, 0});
    tbl.push_back('{0, 8'h66, 0, 1, 0, 1, 8'h55, 1, 0, 0});
    tbl.push_back('{0, 8'h77, 1, 1, 0, 1, 8'h55, 0, 0, 1});
    tbl.push_back('{0, 8'h88, 1, 1, 1, 1, 8'h88, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h88, 0, 0, 0});
    tbl.push_back('{1, 8'h00, 0, 0, 0, 0, 8'h88, 0, 0, 0});

    foreach (tbl[i]) begin
      nm = $sformatf("tbl%0d", i);
      if (tbl[i].is_ack) begin
        do_ack();
        chk({nm, "_valid"}, rx_valid, tbl[i].ev);
        chk({nm, "_data"}, rx_data, tbl[i].ed);
        chk({nm, "_ovf"}, rx_overflow, tbl[i].eo);
      end else begin
        do_frame(tbl[i].d, tbl[i].pok, tbl[i].stp, tbl[i].ack);
        chk({nm, "_valid"}, rx_valid, tbl[i].ev);
        chk({nm, "_data"}, rx_data, tbl[i].ed);
        chk({nm, "_perr"}, parity_err, tbl[i].ep);
        chk({nm, "_ferr"}, frame_err, tbl[i].ef);
        chk({nm, "_ovf"}, rx_overflow, tbl[i].eo);
        end_frame(nm);
      end
    end

    // Abandoned frame: frame_err exactly TO cycles after the last fall.
    send_bits(mk_bits(8'h12, 1, 1), 5, 0);
    got = -1;
    for (int k = 1; k <= 2 * TO; k++) begin
      @(posedge clk); #1;
      if (k == 3) ps2_clk_f = 1'b1;
      if (frame_err) begin
        got = k;
        break;
      end
    end
    x_ferr++;
    chk("timeout_latency", got, TO);
    @(posedge clk); #1;
    chk("timeout_pulse_end", frame_err, 0);
    chk("timeout_valid", rx_valid, 0);
    do_frame(8'h12, 1, 1, 0);
    chk_model("after_timeout");
    chk("after_timeout_data", rx_data, 8'h12);
    end_frame("after_timeout");
    do_ack();

    // Reset in the middle of a frame.
    do_frame(8'h3C, 1, 1, 0);
    end_frame("pre_rst");
    send_bits(mk_bits(8'hC3, 1, 1), 6, 0);
    @(posedge clk); #1;
    rstn      = 1'b0;
    ps2_clk_f = 1'b1;
    model_reset();
    @(negedge clk);
    chk("midrst_data", rx_data, 0);
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_ovf", rx_overflow, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_ferr", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    do_frame(8'hA5, 1, 1, 0);
    chk_model("after_rst");
    chk("after_rst_data", rx_data, 8'hA5);
    end_frame("after_rst");

    for (int r = 0; r < 40; r++) begin
      nm = $sformatf("rnd%0d", r);
      if ($urandom_range(0, 2) == 0) begin
        send_bits(11'h7FF, $urandom_range(1, 3), 0);
        rise();
        repeat (2) @(posedge clk);
      end
      if ($urandom_range(0, 3) == 0) begin
        do_ack();
        chk_model({nm, "_ack"});
      end else begin
        do_frame(8'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 3) == 0);
        chk_model(nm);
        chk({nm, "_perr"}, parity_err, m_pe);
        chk({nm, "_ferr"}, frame_err, m_fe);
        end_frame(nm);
      end
    end

    repeat (5) @(posedge clk);
    chk("total_parity_pulses", n_perr, x_perr);
    chk("total_frame_pulses", n_ferr, x_ferr);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
